// File: rtl/dsp_simd_alu.sv
// dsp_simd_alu: 48-bit DSP-slice ALU (no multiplier): X/Y/Z/W operand muxes, SIMD add/subtract
// lanes, bitwise logic unit and optional P register. Define DSP_SIMD_ALU_CARRYOUT_EN for carryout[3:0].
module dsp_simd_alu #(
    parameter int SIMD = 4,
    parameter int PREG = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce_p,
    input  logic [3:0]  alumode,
    input  logic [8:0]  opmode,
    input  logic        carryin,
    input  logic [29:0] a,
    input  logic [17:0] b,
    input  logic [47:0] c,
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
    output logic [3:0]  carryout,
`endif
    output logic [47:0] p
);

    localparam int LW = 48 / ((SIMD > 0) ? SIMD : 1);
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
    localparam int SW = LW + 1;
`else
    localparam int SW = LW;
`endif

    if (SIMD != 1 && SIMD != 2 && SIMD != 4) begin : g_bad_simd
        $error("dsp_simd_alu: SIMD must be 1, 2 or 4");
    end

    logic [47:0] ab, pfb, x, y, z, w;
    logic [47:0] arith_res, logic_res, result;

    assign ab = {a, b};

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        x = '0;
        y = '0;
        z = '0;
        w = '0;
        case (opmode[1:0])
            2'b10:   x = pfb;
            2'b11:   x = ab;
            default: x = '0;
        endcase
        case (opmode[3:2])
            2'b10:   y = '1;
            2'b11:   y = c;
            default: y = '0;
        endcase
        case (opmode[6:4])
            3'b010:  z = pfb;
            3'b011:  z = c;
            default: z = '0;
        endcase
        case (opmode[8:7])
            2'b01:   w = pfb;
            2'b11:   w = c;
            default: w = '0;
        endcase
    end

`ifdef DSP_SIMD_ALU_CARRYOUT_EN
    logic [SIMD-1:0] lane_co;
    logic [3:0]      co_lanes, co_res;
`endif

    // Each lane sums in isolation; subtract is ~(~Z + W + X + Y + cin).
    for (genvar i = 0; i < SIMD; i++) begin : g_lane
        logic          cin_l;
        logic [LW-1:0] z_l;
        logic [SW-1:0] sum;
        assign cin_l = (i == 0) ? carryin : 1'b0;
        assign z_l   = alumode[0] ? ~z[i*LW +: LW] : z[i*LW +: LW];
        assign sum   = SW'(z_l) + SW'(w[i*LW +: LW]) + SW'(x[i*LW +: LW])
                     + SW'(y[i*LW +: LW]) + SW'(cin_l);
        assign arith_res[i*LW +: LW] = alumode[1] ? ~sum[LW-1:0] : sum[LW-1:0];
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
        assign lane_co[i] = sum[LW];
`endif
    end

    always_comb begin
        logic_res = '0;
        if (opmode[3:2] == 2'b00) begin
            case (alumode)
                4'b0100, 4'b0111: logic_res = x ^ z;
                4'b0101, 4'b0110: logic_res = ~(x ^ z);
                4'b1100:          logic_res = x & z;
                4'b1101:          logic_res = x & ~z;
                4'b1110:          logic_res = ~(x & z);
                4'b1111:          logic_res = ~x & z;
                default:          logic_res = '0;
            endcase
        end else if (opmode[3:2] == 2'b10) begin
            case (alumode)
                4'b0100, 4'b0111: logic_res = ~(x ^ z);
                4'b0101, 4'b0110: logic_res = x ^ z;
                4'b1100:          logic_res = x | z;
                4'b1101:          logic_res = x | ~z;
                4'b1110:          logic_res = ~(x | z);
                4'b1111:          logic_res = ~x | z;
                default:          logic_res = '0;
            endcase
        end
    end

    always_comb begin
        result = '0;
        if (alumode[3:2] == 2'b00) begin
            result = arith_res;
        end else if (alumode[2]) begin
            result = logic_res;
        end
    end

`ifdef DSP_SIMD_ALU_CARRYOUT_EN
    if (SIMD == 4) begin : g_co4
        assign co_lanes = lane_co;
    end else if (SIMD == 2) begin : g_co2
        assign co_lanes = {lane_co[1], 1'b0, lane_co[0], 1'b0};
    end else begin : g_co1
        assign co_lanes = {lane_co[0], 3'b000};
    end
    assign co_res = (alumode[3:2] == 2'b00) ? co_lanes : 4'b0000;
`endif

    if (PREG == 1) begin : g_preg
        logic [47:0] p_q, p_d;
        assign p_d = result;
        // NOTE: register state is updated with non-blocking assignments only.
        always_ff @(posedge clock) begin
            if (reset) begin
                p_q <= '0;
            end else if (ce_p) begin
                p_q <= p_d;
            end
        end
        assign p   = p_q;
        assign pfb = p_q;
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
        logic [3:0] co_q, co_d;
        assign co_d = co_res;
        always_ff @(posedge clock) begin
            if (reset) begin
                co_q <= '0;
            end else if (ce_p) begin
                co_q <= co_d;
            end
        end
        assign carryout = co_q;
`endif
    end else begin : g_nopreg
        // Without the register, feedback is tied off so there is no combinational loop.
        logic unused_regctl;
        assign unused_regctl = ^{clock, reset, ce_p};
        assign p   = result;
        assign pfb = '0;
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
        assign carryout = co_res;
`endif
    end

endmodule

// File: tb/tb_dsp_simd_alu.sv
// tb_dsp_simd_alu: directed and randomized checks of dsp_simd_alu against an arithmetic reference model.
// Four instances share the inputs: SIMD 4/2/1 combinational, and SIMD 4 with the P register.
module tb_dsp_simd_alu;

    logic        clock = 1'b0;
    logic        reset, ce_p, carryin;
    logic [3:0]  alumode;
    logic [8:0]  opmode;
    logic [29:0] a;
    logic [17:0] b;
    logic [47:0] c;
    logic [47:0] p_s4, p_s2, p_s1, p_acc;
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
    logic [3:0]  co_s4, co_s2, co_s1, co_acc;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    dsp_simd_alu #(.SIMD(4), .PREG(0)) u_s4 (
        .clock(clock), .reset(reset), .ce_p(ce_p), .alumode(alumode), .opmode(opmode),
        .carryin(carryin), .a(a), .b(b), .c(c),
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
        .carryout(co_s4),
`endif
        .p(p_s4));

    dsp_simd_alu #(.SIMD(2), .PREG(0)) u_s2 (
        .clock(clock), .reset(reset), .ce_p(ce_p), .alumode(alumode), .opmode(opmode),
        .carryin(carryin), .a(a), .b(b), .c(c),
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
        .carryout(co_s2),
`endif
        .p(p_s2));

    dsp_simd_alu #(.SIMD(1), .PREG(0)) u_s1 (
        .clock(clock), .reset(reset), .ce_p(ce_p), .alumode(alumode), .opmode(opmode),
        .carryin(carryin), .a(a), .b(b), .c(c),
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
        .carryout(co_s1),
`endif
        .p(p_s1));

    dsp_simd_alu #(.SIMD(4), .PREG(1)) u_acc (
        .clock(clock), .reset(reset), .ce_p(ce_p), .alumode(alumode), .opmode(opmode),
        .carryin(carryin), .a(a), .b(b), .c(c),
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
        .carryout(co_acc),
`endif
        .p(p_acc));

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] alu, input logic [8:0] op, input logic cin,
                          input logic [47:0] ab, input logic [47:0] cc);
        alumode = alu;
        opmode  = op;
        carryin = cin;
        {a, b}  = ab;
        c       = cc;
        #2;
    endtask

    // Returns {carryout, p}. Lane results use plain modular integer arithmetic.
    function automatic logic [51:0] model(input int simd, input logic [3:0] alu, input logic [8:0] op,
                                          input logic cin, input logic [47:0] ab,
                                          input logic [47:0] cc, input logic [47:0] pfb);
        logic [47:0]     x, y, z, w, r;
        logic [3:0]      co;
        logic [63:0]     x64, y64, z64, w64;
        longint unsigned m, xl, yl, zl, wl, addend, raw, res;
        int              lw;
        x = (op[1:0] == 2'b11) ? ab : (op[1:0] == 2'b10) ? pfb : 48'd0;
        y = (op[3:2] == 2'b11) ? cc : (op[3:2] == 2'b10) ? {48{1'b1}} : 48'd0;
        z = (op[6:4] == 3'b011) ? cc : (op[6:4] == 3'b010) ? pfb : 48'd0;
        w = (op[8:7] == 2'b11) ? cc : (op[8:7] == 2'b01) ? pfb : 48'd0;
        r  = '0;
        co = '0;
        lw = 48 / simd;
        m  = 64'd1 << lw;
        x64 = {16'd0, x};
        y64 = {16'd0, y};
        z64 = {16'd0, z};
        w64 = {16'd0, w};
        if (alu[3:2] == 2'b00) begin
            for (int i = 0; i < simd; i++) begin
                xl = (x64 >> (i * lw)) % m;
                yl = (y64 >> (i * lw)) % m;
                zl = (z64 >> (i * lw)) % m;
                wl = (w64 >> (i * lw)) % m;
                addend = wl + xl + yl;
                if (i == 0) addend += 64'(cin);
                case (alu[1:0])
                    2'b00:   begin raw = zl + addend;           res = raw % m; end
                    2'b01:   begin raw = (m - 1 - zl) + addend; res = raw % m; end
                    2'b10:   begin raw = zl + addend;           res = (m - 1) - (raw % m); end
                    default: begin raw = (m - 1 - zl) + addend; res = (zl + 4 * m - addend) % m; end
                endcase
                r = r | 48'(res << (i * lw));
                co[(i + 1) * (4 / simd) - 1] = ((raw >> lw) & 64'd1) != 0;
            end
        end else if (alu[2]) begin
            if (op[3:2] == 2'b00) begin
                case (alu)
                    4'b0100, 4'b0111: r = x ^ z;
                    4'b0101, 4'b0110: r = x ~^ z;
                    4'b1100:          r = x & z;
                    4'b1101:          r = x & ~z;
                    4'b1110:          r = ~(x & z);
                    default:          r = ~x & z;
                endcase
            end else if (op[3:2] == 2'b10) begin
                case (alu)
                    4'b0100, 4'b0111: r = x ~^ z;
                    4'b0101, 4'b0110: r = x ^ z;
                    4'b1100:          r = x | z;
                    4'b1101:          r = x | ~z;
                    4'b1110:          r = ~(x | z);
                    default:          r = ~x | z;
                endcase
            end
        end
        return {co, r};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  alu;
        logic [8:0]  op;
        logic        cin;
        logic [47:0] ab, cc, acc_q;
        logic [51:0] mres;
        logic [3:0]  acc_co;

        reset = 1'b1;
        ce_p  = 1'b0;
        set_in(4'b0000, 9'd0, 1'b0, 48'd0, 48'd0);
        @(posedge clock); #1;
        check("reset_p", p_acc, 48'd0);
        reset = 1'b0;

        set_in(4'b1100, 9'b000111011, 1'b0, {12'h000, 12'h400, 12'h005, 12'h00F},
               {12'h000, 12'h123, 12'h00A, 12'h0F0});
        check("or_4lane", p_s4, {12'h000, 12'h523, 12'h00F, 12'h0FF});

        set_in(4'b0000, 9'b000110011, 1'b1, 48'h7FF_FFF_FFF_FFF, 48'h7FF_FFF_FFF_FFF);
        check("lane_iso_s4", p_s4, 48'hFFE_FFE_FFE_FFF);
        check("lane_iso_s2", p_s2, 48'hFFF_FFE_FFF_FFF);
        check("lane_iso_s1", p_s1, 48'hFFF_FFF_FFF_FFF);
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
        mres = model(4, alumode, opmode, carryin, {a, b}, c, 48'd0);
        check("lane_iso_co", {44'd0, co_s4}, {44'd0, mres[51:48]});
`endif

        set_in(4'b0011, 9'b000110011, 1'b0, 48'd30, 48'd100);
        check("sub_s1", p_s1, 48'd70);
        check("sub_s4", p_s4, 48'd70);
        set_in(4'b0011, 9'b000110011, 1'b0, 48'd101, 48'd100);
        check("sub_neg_s1", p_s1, 48'hFFFF_FFFF_FFFF);

        set_in(4'b1100, 9'b000110011, 1'b0, 48'hF0F0_F0F0_F0F0, 48'hFF00_FF00_FF00);
        check("logic_and", p_s4, 48'hF000_F000_F000);
        set_in(4'b0100, 9'b000110011, 1'b1, 48'hF0F0_F0F0_F0F0, 48'hFF00_FF00_FF00);
        check("logic_xor", p_s4, 48'h0FF0_0FF0_0FF0);
        set_in(4'b1110, 9'b000110011, 1'b0, 48'hF0F0_F0F0_F0F0, 48'hFF00_FF00_FF00);
        check("logic_nand", p_s1, 48'h0FFF_0FFF_0FFF);

        set_in(4'b0000, 9'b000000001, 1'b0, 48'h1234_5678_9ABC, 48'h0);
        check("x_sel01_zero", p_s4, 48'd0);
        set_in(4'b1000, 9'b000110011, 1'b1, 48'h1234_5678_9ABC, 48'h1111_1111_1111);
        check("alu1000_zero_s4", p_s4, 48'd0);
        check("alu1000_zero_s1", p_s1, 48'd0);

        // Accumulate X=AB=5 into Z=PFB.
        set_in(4'b0000, 9'b000100011, 1'b0, 48'd5, 48'd0);
        check("acc_comb_nofb", p_s4, 48'd5);
        reset = 1'b1;
        ce_p  = 1'b1;
        @(posedge clock); #1;
        check("acc_reset", p_acc, 48'd0);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock); #1;
            check("acc_step", p_acc, 48'(5 * k));
        end
        ce_p = 1'b0;
        @(posedge clock); #1;
        check("acc_hold1", p_acc, 48'd15);
        @(posedge clock); #1;
        check("acc_hold2", p_acc, 48'd15);
        reset = 1'b1;
        ce_p  = 1'b1;
        @(posedge clock); #1;
        check("acc_midreset", p_acc, 48'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("acc_restart", p_acc, 48'd5);

        acc_q  = 48'd5;
        acc_co = mres[51:48];
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
        acc_co = co_acc;
`endif
        for (int n = 0; n < 120; n++) begin
            alu   = 4'($urandom);
            op    = 9'($urandom);
            cin   = 1'($urandom);
            ab    = 48'({$urandom, $urandom});
            cc    = 48'({$urandom, $urandom});
            ce_p  = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 9) == 0);
            set_in(alu, op, cin, ab, cc);
            mres = model(4, alu, op, cin, ab, cc, 48'd0);
            check("rand_s4", p_s4, mres[47:0]);
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
            check("rand_co_s4", {44'd0, co_s4}, {44'd0, mres[51:48]});
`endif
            mres = model(2, alu, op, cin, ab, cc, 48'd0);
            check("rand_s2", p_s2, mres[47:0]);
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
            check("rand_co_s2", {44'd0, co_s2}, {44'd0, mres[51:48]});
`endif
            mres = model(1, alu, op, cin, ab, cc, 48'd0);
            check("rand_s1", p_s1, mres[47:0]);
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
            check("rand_co_s1", {44'd0, co_s1}, {44'd0, mres[51:48]});
`endif
            mres = model(4, alu, op, cin, ab, cc, acc_q);
            if (reset) begin
                acc_q  = '0;
                acc_co = '0;
            end else if (ce_p) begin
                acc_q  = mres[47:0];
                acc_co = mres[51:48];
            end
            @(posedge clock); #1;
            check("rand_acc", p_acc, acc_q);
`ifdef DSP_SIMD_ALU_CARRYOUT_EN
            check("rand_co_acc", {44'd0, co_acc}, {44'd0, acc_co});
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
